// File: rtl/alu_control.sv
// Sequencer for the shared combinational ALU. It accepts one instruction per handshake,
// feeds operands from an internal register file, and writes results and flags back.
module alu_control #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [4:0]       instr_op,
  input  logic [2:0]       instr_rd,
  input  logic [2:0]       instr_ra,
  input  logic [2:0]       instr_rb,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_resultado,
  input  logic             alu_c,
  input  logic             alu_s,
  input  logic             alu_o,
  input  logic             alu_z,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_s,
  output logic             flag_o,
  output logic             flag_z,
  output logic             halted
);

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_NEG = 5'h05;
  localparam logic [4:0] OP_NOT = 5'h06;
  localparam logic [4:0] OP_HLT = 5'h1F;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HALT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [4:0]       opcode_q, opcode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       rd_q, rd_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             wbEn;
  logic             isAluOp;

  assign instr_ready = (state_q == IDLE) && !rst;
  assign halted      = (state_q == HALT);
  assign dbg_data    = regs_q[dbg_addr];
  assign alu_opcode  = opcode_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign done        = done_q;
  assign result      = result_q;
  assign {flag_c, flag_s, flag_o, flag_z} = flags_q;

  // Only real ALU operations commit a result; NOP, HLT and undefined opcodes do not.
  always_comb begin
    isAluOp = 1'b0;
    case (opcode_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT: isAluOp = 1'b1;
      default: isAluOp = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    wbEn     = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          opcode_d = instr_op;
          a_d      = regs_q[instr_ra];
          b_d      = regs_q[instr_rb];
          rd_d     = instr_rd;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        done_d   = 1'b1;
        opcode_d = OP_NOP;
        if (isAluOp) begin
          wbEn     = 1'b1;
          result_d = alu_resultado;
          flags_d  = {alu_c, alu_s, alu_o, alu_z};
        end
        state_d = (opcode_q == OP_HLT) ? HALT : IDLE;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opcode_q <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Writeback is issued after the host write so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        regs_q[wr_addr] <= wr_data;
      end
      if (wbEn) begin
        regs_q[rd_q] <= alu_resultado;
      end
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Bench for alu_control: supplies a behavioural ALU, runs directed and random
// instructions, and compares against a register-file model held in the bench.
module tb_alu_control;

  localparam int WIDTH = 32;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_NEG = 5'h05;
  localparam logic [4:0] OP_NOT = 5'h06;
  localparam logic [4:0] OP_HLT = 5'h1F;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic             instr_ready;
  logic [4:0]       instr_op;
  logic [2:0]       instr_rd, instr_ra, instr_rb;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [2:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_data;
  logic [4:0]       alu_opcode;
  logic [WIDTH-1:0] alu_a, alu_b, alu_resultado;
  logic             alu_c, alu_s, alu_o, alu_z;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_c, flag_s, flag_o, flag_z;
  logic             halted;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  logic [WIDTH-1:0] refRegs [8];
  logic [WIDTH-1:0] refResult;
  logic             refC, refS, refO, refZ, refHalted;

  always #5 clk = ~clk;

  alu_control #(.WIDTH(WIDTH), .NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_resultado(alu_resultado), .alu_c(alu_c), .alu_s(alu_s), .alu_o(alu_o), .alu_z(alu_z),
    .done(done), .result(result),
    .flag_c(flag_c), .flag_s(flag_s), .flag_o(flag_o), .flag_z(flag_z),
    .halted(halted)
  );

  // Behavioural ALU, packed as {c, s, o, z, result}; non-ALU opcodes yield a^b so stray writes show up.
  function automatic logic [WIDTH+3:0] aluEval(input logic [4:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic             c, o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        o    = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = a - b;
        c   = (a < b);
        o   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NEG: begin
        res = -a;
        c   = (a != '0);
        o   = (a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_NOT: res = ~a;
      default: begin
        res = a ^ b;
        c   = 1'b1;
      end
    endcase
    return {c, res[WIDTH-1], o, (res == '0), res};
  endfunction

  function automatic logic isAlu(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT};
  endfunction

  always_comb begin
    {alu_c, alu_s, alu_o, alu_z, alu_resultado} = aluEval(alu_opcode, alu_a, alu_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed, input logic [WIDTH-1:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) refRegs[i] = '0;
    refResult = '0;
    {refC, refS, refO, refZ} = 4'b0000;
    refHalted = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    instr_valid = 1'b1;
    wr_en = 1'b0;
    tick();
    checkFlag("rst_ready", instr_ready, 1'b0);
    checkFlag("rst_done", done, 1'b0);
    checkFlag("rst_halted", halted, 1'b0);
    checkOutput("rst_opcode", 32'(alu_opcode), 32'(OP_NOP));
    checkOutput("rst_result", result, '0);
    checkOutput("rst_flags", 32'({flag_c, flag_s, flag_o, flag_z}), '0);
    tick();
    checkFlag("rst_ready_hold", instr_ready, 1'b0);
    rst = 1'b0;
    instr_valid = 1'b0;
    modelReset();
    #1;
    checkFlag("ready_after_rst", instr_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checkOutput("rst_reg", dbg_data, refRegs[i]);
    end
    tick();
  endtask

  task automatic hostWrite(input logic [2:0] addr, input logic [WIDTH-1:0] data);
    instr_valid = 1'b0;
    wr_en = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
    refRegs[addr] = data;
    checkFlag("done_idle", done, 1'b0);
  endtask

  // Issues one instruction from IDLE and checks the EXEC cycle and the completion cycle.
  task automatic applyStimulus(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                               input logic hostEn, input logic [2:0] hostAddr, input logic [WIDTH-1:0] hostData);
    logic [WIDTH+3:0] ev;
    logic [WIDTH-1:0] expA, expB;
    logic [2:0]       probe;
    instr_valid = 1'b1;
    instr_op = op;
    instr_rd = rd;
    instr_ra = ra;
    instr_rb = rb;
    checkFlag("ready_idle", instr_ready, 1'b1);
    expA = refRegs[ra];
    expB = refRegs[rb];
    tick();
    checkFlag("ready_exec", instr_ready, 1'b0);
    checkFlag("done_exec", done, 1'b0);
    checkOutput("alu_opcode", 32'(alu_opcode), 32'(op));
    checkOutput("alu_a", alu_a, expA);
    checkOutput("alu_b", alu_b, expB);
    wr_en = hostEn;
    wr_addr = hostAddr;
    wr_data = hostData;
    tick();
    wr_en = 1'b0;
    if (hostEn) refRegs[hostAddr] = hostData;
    ev = aluEval(op, expA, expB);
    if (isAlu(op)) begin
      refRegs[rd] = ev[WIDTH-1:0];
      refResult = ev[WIDTH-1:0];
      {refC, refS, refO, refZ} = ev[WIDTH+3:WIDTH];
    end else if (op == OP_HLT) begin
      refHalted = 1'b1;
    end
    checkFlag("done_pulse", done, 1'b1);
    checkOutput("result", result, refResult);
    checkFlag("flag_c", flag_c, refC);
    checkFlag("flag_s", flag_s, refS);
    checkFlag("flag_o", flag_o, refO);
    checkFlag("flag_z", flag_z, refZ);
    checkFlag("halted", halted, refHalted);
    checkFlag("ready_after", instr_ready, !refHalted);
    checkOutput("opcode_nop", 32'(alu_opcode), 32'(OP_NOP));
    dbg_addr = rd;
    #1;
    checkOutput("reg_rd", dbg_data, refRegs[rd]);
    probe = 3'($urandom_range(7, 0));
    dbg_addr = probe;
    #1;
    checkOutput("reg_probe", dbg_data, refRegs[probe]);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_op = OP_NOP;
    instr_rd = '0;
    instr_ra = '0;
    instr_rb = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    dbg_addr = '0;
    modelReset();
    resetDut();

    $display("[TB] directed ADD / OR / SUB sequence");
    hostWrite(3'd1, 32'hFFFF_0000);
    hostWrite(3'd2, 32'hFFFF_FFFF);
    hostWrite(3'd5, 32'h0000_FFFF);
    applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, '0);
    checkOutput("add_result_const", result, 32'hFFFE_FFFF);
    checkFlag("add_c_const", flag_c, 1'b1);
    checkFlag("add_s_const", flag_s, 1'b1);
    applyStimulus(OP_OR, 3'd4, 3'd1, 3'd5, 1'b0, 3'd0, '0);
    checkOutput("or_result_const", result, 32'hFFFF_FFFF);
    applyStimulus(OP_SUB, 3'd6, 3'd1, 3'd1, 1'b0, 3'd0, '0);
    checkFlag("sub_z_const", flag_z, 1'b1);

    $display("[TB] NOP, unknown opcode and write collisions");
    applyStimulus(OP_NOP, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, '0);
    applyStimulus(5'h11, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, '0);
    applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b1, 3'd3, 32'h1234_5678);
    applyStimulus(OP_ADD, 3'd0, 3'd1, 3'd5, 1'b1, 3'd7, 32'h1234_5678);
    dbg_addr = 3'd7;
    #1;
    checkOutput("r7_host_const", dbg_data, 32'h1234_5678);

    $display("[TB] random instructions");
    for (int i = 0; i < 8; i++) hostWrite(3'(i), $urandom());
    hostWrite(3'd6, 32'h8000_0000);
    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      op = 5'($urandom_range(31, 0));
      if (op == OP_HLT) op = OP_NOP;
      if ($urandom_range(1, 0) == 1) op = 5'($urandom_range(6, 1));
      applyStimulus(op, 3'($urandom), 3'($urandom), 3'($urandom),
                    1'($urandom), 3'($urandom), $urandom());
    end

    $display("[TB] reset during EXEC");
    hostWrite(3'd2, 32'hA5A5_A5A5);
    instr_valid = 1'b1;
    instr_op = OP_AND;
    instr_rd = 3'd2;
    instr_ra = 3'd1;
    instr_rb = 3'd5;
    tick();
    checkFlag("midrst_exec", instr_ready, 1'b0);
    rst = 1'b1;
    instr_valid = 1'b0;
    tick();
    rst = 1'b0;
    modelReset();
    #1;
    checkFlag("midrst_done", done, 1'b0);
    checkFlag("midrst_ready", instr_ready, 1'b1);
    checkOutput("midrst_flags", 32'({flag_c, flag_s, flag_o, flag_z}), '0);
    dbg_addr = 3'd2;
    #1;
    checkOutput("midrst_r2", dbg_data, refRegs[2]);
    tick();
    checkFlag("midrst_no_late_done", done, 1'b0);

    $display("[TB] halt behaviour");
    hostWrite(3'd1, 32'h0000_0010);
    applyStimulus(OP_NEG, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, '0);
    applyStimulus(OP_HLT, 3'd5, 3'd1, 3'd1, 1'b0, 3'd0, '0);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkFlag("halt_ready", instr_ready, 1'b0);
      checkFlag("halt_flag", halted, 1'b1);
      checkFlag("halt_done", done, 1'b0);
    end
    hostWrite(3'd7, 32'hCAFE_F00D);
    dbg_addr = 3'd7;
    #1;
    checkOutput("halt_host_write", dbg_data, 32'hCAFE_F00D);
    checkFlag("halt_still", halted, 1'b1);
    resetDut();
    checkFlag("halt_cleared", halted, 1'b0);
    hostWrite(3'd1, 32'h7FFF_FFFF);
    applyStimulus(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 3'd0, '0);
    checkFlag("ovf_const", flag_o, 1'b1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
